// File: rtl/sdram_responder.sv
// Device-side SDRAM model: decodes controller commands, tracks open rows per
// bank, stores write bursts and returns read bursts through a CAS-latency
// delay line.
module sdram_responder #(
    parameter int ROW_W  = 4,
    parameter int COL_W  = 8,
    parameter int CL_RST = 1,
    parameter int BL_RST = 3
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        MEM_CKE,
    input  logic        MEM_CSn,
    input  logic        MEM_RASn,
    input  logic        MEM_CASn,
    input  logic        MEM_WEn,
    input  logic [1:0]  MEM_BA,
    input  logic [11:0] MEM_ADDR,
    input  logic [31:0] MEM_WDATA,
    input  logic [3:0]  MEM_DQM,
    output logic [31:0] MEM_RDATA,
    output logic        RDATA_VALID,
    output logic        CMD_ERR,
    output logic [15:0] REF_CNT
);
    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] CL_INIT = 2'(CL_RST);
    localparam logic [1:0] BL_INIT = 2'(BL_RST);

    localparam logic [3:0] CMD_ACTIVE = 4'b0011;
    localparam logic [3:0] CMD_READ   = 4'b0101;
    localparam logic [3:0] CMD_WRITE  = 4'b0100;
    localparam logic [3:0] CMD_BTERM  = 4'b0110;
    localparam logic [3:0] CMD_PRECH  = 4'b0010;
    localparam logic [3:0] CMD_AREF   = 4'b0001;
    localparam logic [3:0] CMD_LMR    = 4'b0000;

    // Column of a burst word: wraps inside the BL-aligned block.
    function automatic logic [COL_W-1:0] burst_col(input logic [COL_W-1:0] start,
                                                   input logic [2:0] idx,
                                                   input logic [1:0] blc);
        logic [COL_W-1:0] mask;
        logic [COL_W-1:0] step;
        mask = COL_W'(3'b111 >> (2'd3 - blc));
        step = start + COL_W'(idx);
        return (start & ~mask) | (step & mask);
    endfunction

    // Byte-lane merge: a set DQM bit keeps the old byte.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0] dqm);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = dqm[b] ? old_w[8*b +: 8] : new_w[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0] mem_q [DEPTH];

    logic [1:0]       cl_q, cl_d, bl_q, bl_d;
    logic [3:0]       open_q, open_d;
    logic [ROW_W-1:0] row_q [4];
    logic [ROW_W-1:0] row_d [4];
    logic             burst_act_q, burst_act_d, burst_wr_q, burst_wr_d;
    logic [1:0]       burst_ba_q, burst_ba_d;
    logic [ROW_W-1:0] burst_row_q, burst_row_d;
    logic [COL_W-1:0] burst_col_q, burst_col_d;
    logic [2:0]       burst_idx_q, burst_idx_d;
    logic [1:0]       burst_bl_q, burst_bl_d, burst_cl_q, burst_cl_d;
    logic [2:0]       pv_q, pv_d;
    logic [2:0][31:0] pd_q, pd_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d, cmd_err_q, cmd_err_d;
    logic [15:0]      ref_q, ref_d;

    logic [3:0]       cmd_s;
    logic             word_go_s, word_wr_s, word_last_s, mem_we_s, unused_ok_s;
    logic [1:0]       word_ba_s, word_bl_s, word_cl_s;
    logic [ROW_W-1:0] word_row_s;
    logic [COL_W-1:0] word_start_s, word_col_s;
    logic [2:0]       word_idx_s;
    logic [AW-1:0]    word_addr_s;
    logic [31:0]      mem_wdata_s;

    assign unused_ok_s = ^MEM_ADDR;

    // Command decode, burst sequencing and read delay-line next state.
    always_comb begin
        cmd_s        = {MEM_CSn, MEM_RASn, MEM_CASn, MEM_WEn};
        cl_d         = cl_q;
        bl_d         = bl_q;
        open_d       = open_q;
        row_d        = row_q;
        burst_act_d  = burst_act_q;
        burst_wr_d   = burst_wr_q;
        burst_ba_d   = burst_ba_q;
        burst_row_d  = burst_row_q;
        burst_col_d  = burst_col_q;
        burst_idx_d  = burst_idx_q;
        burst_bl_d   = burst_bl_q;
        burst_cl_d   = burst_cl_q;
        pv_d         = pv_q;
        pd_d         = pd_q;
        rdata_d      = rdata_q;
        rvalid_d     = rvalid_q;
        cmd_err_d    = 1'b0;
        ref_d        = ref_q;
        word_go_s    = 1'b0;
        word_wr_s    = burst_wr_q;
        word_ba_s    = burst_ba_q;
        word_row_s   = burst_row_q;
        word_start_s = burst_col_q;
        word_idx_s   = burst_idx_q;
        word_bl_s    = burst_bl_q;
        word_cl_s    = burst_cl_q;
        mem_we_s     = 1'b0;
        word_col_s   = burst_col(word_start_s, word_idx_s, word_bl_s);
        word_addr_s  = {word_ba_s, word_row_s, word_col_s};
        mem_wdata_s  = merge_lanes(mem_q[word_addr_s], MEM_WDATA, MEM_DQM);
        if (MEM_CKE) begin
            // Delay line advances; the oldest entry drives the output register.
            pv_d = {1'b0, pv_q[2:1]};
            pd_d = {32'd0, pd_q[2:1]};
            if (pv_q[0]) begin
                rdata_d  = pd_q[0];
                rvalid_d = 1'b1;
            end else begin
                rvalid_d = 1'b0;
            end
            word_go_s = burst_act_q;
            if (!MEM_CSn) begin
                case (cmd_s)
                    CMD_ACTIVE: begin
                        if (open_q[MEM_BA]) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            open_d[MEM_BA] = 1'b1;
                            row_d[MEM_BA]  = MEM_ADDR[ROW_W-1:0];
                        end
                    end
                    CMD_READ, CMD_WRITE: begin
                        if (!open_q[MEM_BA]) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            word_go_s    = 1'b1;
                            word_wr_s    = (cmd_s == CMD_WRITE);
                            word_ba_s    = MEM_BA;
                            word_row_s   = row_q[MEM_BA];
                            word_start_s = MEM_ADDR[COL_W-1:0];
                            word_idx_s   = 3'd0;
                            word_bl_s    = bl_q;
                            word_cl_s    = cl_q;
                            burst_wr_d   = word_wr_s;
                            burst_ba_d   = MEM_BA;
                            burst_row_d  = row_q[MEM_BA];
                            burst_col_d  = MEM_ADDR[COL_W-1:0];
                            burst_bl_d   = bl_q;
                            burst_cl_d   = cl_q;
                        end
                    end
                    CMD_BTERM: begin
                        word_go_s = 1'b0;
                    end
                    CMD_PRECH: begin
                        if (MEM_ADDR[10]) begin
                            open_d = 4'b0000;
                        end else begin
                            open_d[MEM_BA] = 1'b0;
                        end
                        // A write burst cannot continue into a closed bank.
                        if (burst_wr_q && (MEM_ADDR[10] || (MEM_BA == burst_ba_q))) begin
                            word_go_s = 1'b0;
                        end else begin
                            word_go_s = burst_act_q;
                        end
                    end
                    CMD_AREF: begin
                        ref_d     = ref_q + 16'd1;
                        cmd_err_d = |open_q;
                    end
                    CMD_LMR: begin
                        if ((|open_q) || MEM_ADDR[6] || (MEM_ADDR[5:4] == 2'd0) || MEM_ADDR[2]) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            cl_d = MEM_ADDR[5:4];
                            bl_d = MEM_ADDR[1:0];
                        end
                    end
                    default: begin
                        word_go_s = burst_act_q;
                    end
                endcase
            end else begin
                word_go_s = burst_act_q;
            end
            word_col_s  = burst_col(word_start_s, word_idx_s, word_bl_s);
            word_addr_s = {word_ba_s, word_row_s, word_col_s};
            mem_wdata_s = merge_lanes(mem_q[word_addr_s], MEM_WDATA, MEM_DQM);
            word_last_s = (word_idx_s == (3'b111 >> (2'd3 - word_bl_s)));
            if (word_go_s) begin
                burst_idx_d = word_idx_s + 3'd1;
                burst_act_d = !word_last_s;
                if (word_wr_s) begin
                    mem_we_s = 1'b1;
                end else begin
                    case (word_cl_s)
                        2'd1: begin
                            pv_d[0] = 1'b1;
                            pd_d[0] = mem_q[word_addr_s];
                        end
                        2'd2: begin
                            pv_d[1] = 1'b1;
                            pd_d[1] = mem_q[word_addr_s];
                        end
                        default: begin
                            pv_d[2] = 1'b1;
                            pd_d[2] = mem_q[word_addr_s];
                        end
                    endcase
                end
            end else begin
                burst_act_d = 1'b0;
            end
        end else begin
            word_last_s = 1'b0;
        end
    end

    // Storage array: written by write bursts, never cleared.
    always_ff @(posedge HCLK) begin
        if (mem_we_s) begin
            mem_q[word_addr_s] <= mem_wdata_s;
        end
    end

    // Control, burst, delay-line and output registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cl_q        <= CL_INIT;
            bl_q        <= BL_INIT;
            open_q      <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= '0;
            end
            burst_act_q <= 1'b0;
            burst_wr_q  <= 1'b0;
            burst_ba_q  <= 2'd0;
            burst_row_q <= '0;
            burst_col_q <= '0;
            burst_idx_q <= 3'd0;
            burst_bl_q  <= 2'd0;
            burst_cl_q  <= 2'd1;
            pv_q        <= 3'b000;
            pd_q        <= '0;
            rdata_q     <= 32'd0;
            rvalid_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            ref_q       <= 16'd0;
        end else begin
            cl_q        <= cl_d;
            bl_q        <= bl_d;
            open_q      <= open_d;
            row_q       <= row_d;
            burst_act_q <= burst_act_d;
            burst_wr_q  <= burst_wr_d;
            burst_ba_q  <= burst_ba_d;
            burst_row_q <= burst_row_d;
            burst_col_q <= burst_col_d;
            burst_idx_q <= burst_idx_d;
            burst_bl_q  <= burst_bl_d;
            burst_cl_q  <= burst_cl_d;
            pv_q        <= pv_d;
            pd_q        <= pd_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            cmd_err_q   <= cmd_err_d;
            ref_q       <= ref_d;
        end
    end

    assign MEM_RDATA   = rdata_q;
    assign RDATA_VALID = rvalid_q;
    assign CMD_ERR     = cmd_err_q;
    assign REF_CNT     = ref_q;
endmodule
